// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU width, opcode constants and sequencer state encoding
package alu_pkg;
  localparam int W = 8;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO with occupancy count
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  assign push_ok = push && cnt_q != (AW+1)'(DEPTH);
  assign pop_ok = pop && cnt_q != '0;
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  // next storage, pointers (wrap naturally at power-of-two depth) and count
  always_comb begin
    mem_d = mem_q;
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) begin
      mem_d[wr_q] = wdata;
      wr_d = wr_q + 1'b1;
    end
    if (pop_ok) rd_d = rd_q + 1'b1;
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers ALU commands, issues them one at a time and registers results
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = alu_pkg::W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_acc,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic         alu_zero,
  input  logic         alu_overflow,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_zero,
  output logic         res_ovf,
  output logic [W-1:0] acc_out,
  output logic         ovf_sticky,
  input  logic         clr_sticky,
  output logic         busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = 3 + 2*W + 1;
  logic [AW:0] count;
  logic [DW-1:0] rdata;
  logic push, pop, has;
  logic [2:0] f_op;
  logic [W-1:0] f_a, f_b;
  logic f_acc;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, acc_q, acc_d;
  logic [2:0] op_q, op_d;
  logic zero_q, zero_d, ovf_q, ovf_d, sticky_q, sticky_d;
  alu_cmd_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .wdata({cmd_op, cmd_a, cmd_b, cmd_acc}),
    .pop(pop),
    .rdata(rdata),
    .count(count)
  );
  assign {f_op, f_a, f_b, f_acc} = rdata;
  assign has = count != '0;
  assign cmd_ready = count != (AW+1)'(DEPTH);
  assign push = cmd_valid && cmd_ready;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_op = op_q;
  assign res_valid = state_q == HOLD;
  assign res_data = res_q;
  assign res_zero = zero_q;
  assign res_ovf = ovf_q;
  assign acc_out = acc_q;
  assign ovf_sticky = sticky_q;
  assign busy = state_q != IDLE || has;
  // issue/capture sequencing: pop in IDLE or on a HOLD handshake, capture in EXEC
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    res_d = res_q;
    zero_d = zero_q;
    ovf_d = ovf_q;
    acc_d = acc_q;
    pop = has && (state_q == IDLE || (state_q == HOLD && res_ready));
    if (state_q == EXEC) begin
      res_d = alu_result;
      zero_d = alu_zero;
      ovf_d = alu_overflow;
      acc_d = alu_result;
      state_d = HOLD;
    end
    if (state_q == HOLD && res_ready) state_d = has ? EXEC : IDLE;
    if (state_q == IDLE && has) state_d = EXEC;
    if (pop) begin
      a_d = f_acc ? acc_q : f_a;
      b_d = f_b;
      op_d = f_op;
    end
    sticky_d = (state_q == EXEC && alu_overflow) ? 1'b1 : clr_sticky ? 1'b0 : sticky_q;
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      res_q <= '0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
      acc_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      res_q <= res_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
      acc_q <= acc_d;
      sticky_q <= sticky_d;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and randomized checks against a queue-based model
module tb_alu_op_sequencer;
  import alu_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic acc;
  } cmd_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_acc = 1'b0, res_ready = 1'b0, clr_sticky = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic cmd_ready, alu_zero, alu_overflow, res_valid, res_zero, res_ovf, ovf_sticky, busy;
  logic [7:0] alu_a, alu_b, alu_result, res_data, acc_out;
  logic [2:0] alu_op;
  int tests = 0;
  int fails = 0;
  cmd_t q[$];
  cmd_t cur;
  bit m_exec, m_valid, m_sticky;
  logic [7:0] m_acc, e_data;
  logic e_zero, e_ovf;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(DEPTH), .W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_ovf(res_ovf), .acc_out(acc_out),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky), .busy(busy)
  );

  // returns {overflow, zero, result}
  function automatic logic [9:0] alu_f(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    logic [7:0] r;
    logic v;
    v = 1'b0;
    case (op)
      OP_ADD: begin r = a + b; v = (a[7] == b[7]) && (r[7] != a[7]); end
      OP_SUB: begin r = a - b; v = (a[7] != b[7]) && (r[7] != a[7]); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SHL: r = a << b[2:0];
      OP_SHR: r = a >> b[2:0];
      default: r = {7'd0, $signed(a) < $signed(b)};
    endcase
    return {v, r == 8'd0, r};
  endfunction

  always_comb {alu_overflow, alu_zero, alu_result} = alu_f(alu_op, alu_a, alu_b);

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_exec = 0; m_valid = 0; m_sticky = 0;
      m_acc = '0; e_data = '0; e_zero = 0; e_ovf = 0;
      cur = '{op: 3'd0, a: 8'd0, b: 8'd0, acc: 1'b0};
    end else begin
      bit hs, pu, po;
      logic [9:0] f;
      hs = m_valid && res_ready;
      pu = cmd_valid && q.size() < DEPTH;
      po = q.size() > 0 && !m_exec && (!m_valid || hs);
      if (hs) m_valid = 0;
      if (m_exec) begin
        f = alu_f(cur.op, cur.a, cur.b);
        {e_ovf, e_zero, e_data} = f;
        m_acc = f[7:0];
        m_valid = 1;
        if (f[9]) m_sticky = 1;
        else if (clr_sticky) m_sticky = 0;
      end else if (clr_sticky) m_sticky = 0;
      m_exec = po;
      if (po) begin
        cur = q.pop_front();
        if (cur.acc) cur.a = m_acc;
      end
      if (pu) q.push_back('{op: cmd_op, a: cmd_a, b: cmd_b, acc: cmd_acc});
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("res_valid", res_valid, m_valid);
      chk("cmd_ready", cmd_ready, q.size() < DEPTH);
      chk("busy", busy, m_exec || m_valid || q.size() > 0);
      chk("acc_out", acc_out, m_acc);
      chk("ovf_sticky", ovf_sticky, m_sticky);
      chk("alu_a", alu_a, cur.a);
      chk("alu_b", alu_b, cur.b);
      chk("alu_op", alu_op, cur.op);
      chk("res_data", res_data, e_data);
      chk("res_zero", res_zero, e_zero);
      chk("res_ovf", res_ovf, e_ovf);
    end
  end

  task automatic push(logic [2:0] op, logic [7:0] a, logic [7:0] b, logic acc);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = acc; cmd_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_result();
    int n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) chk("result_timeout", 0, 1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    int acc_n, hs, n;
    logic last_ready;
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_sticky", ovf_sticky, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    // 1: overflowing add, two-edge latency
    push(OP_ADD, 8'h70, 8'h20, 1'b0);
    cmd_valid = 1'b0;
    chk("t1_lat0", res_valid, 0);
    @(negedge clk);
    chk("t1_lat1", res_valid, 0);
    @(negedge clk);
    chk("t1_lat2", res_valid, 1);
    chk("t1_data", res_data, 8'h90);
    chk("t1_ovf", res_ovf, 1);
    chk("t1_zero", res_zero, 0);
    chk("t1_sticky", ovf_sticky, 1);
    chk("t1_acc", acc_out, 8'h90);
    consume();
    // 2: accumulator chaining
    push(OP_ADD, 8'h05, 8'h03, 1'b0);
    push(OP_ADD, 8'hAA, 8'hF8, 1'b1);
    cmd_valid = 1'b0;
    wait_result();
    chk("t2_first", res_data, 8'h08);
    consume();
    wait_result();
    chk("t2_alu_a", alu_a, 8'h08);
    chk("t2_data", res_data, 8'h00);
    chk("t2_zero", res_zero, 1);
    chk("t2_ovf", res_ovf, 0);
    chk("t2_acc", acc_out, 8'h00);
    consume();
    // 3: fill while stalled, then drain
    acc_n = 0;
    last_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_op = OP_ADD; cmd_a = 8'(i * 16); cmd_b = 8'(i + 1); cmd_acc = 1'b0; cmd_valid = 1'b1;
      if (cmd_ready) acc_n++;
      last_ready = cmd_ready;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("t3_accepted", acc_n, 5);
    chk("t3_full_ready", last_ready, 0);
    res_ready = 1'b1;
    hs = 0;
    n = 0;
    do begin
      if (res_valid) hs++;
      @(negedge clk);
      n++;
    end while (busy && n < 40);
    res_ready = 1'b0;
    chk("t3_results", hs, 5);
    chk("t3_cycles", n, 9);
    chk("t3_busy", busy, 0);
    // 4: set wins over clear, then a bare clear
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk("t4_pre_clear", ovf_sticky, 0);
    clr_sticky = 1'b1;
    push(OP_ADD, 8'h7F, 8'h01, 1'b0);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_valid", res_valid, 1);
    chk("t4_set_wins", ovf_sticky, 1);
    clr_sticky = 1'b0;
    consume();
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk("t4_cleared", ovf_sticky, 0);
    // 5: reset in HOLD with two queued
    push(OP_OR, 8'h11, 8'h22, 1'b0);
    push(OP_XOR, 8'h0F, 8'hFF, 1'b0);
    push(OP_AND, 8'hF0, 8'h3C, 1'b0);
    cmd_valid = 1'b0;
    wait_result();
    chk("t5_acc_before", acc_out, 8'h33);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_res_valid", res_valid, 0);
    chk("t5_acc", acc_out, 0);
    chk("t5_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_no_result", res_valid, 0);
    chk("t5_cmd_ready", cmd_ready, 1);
    chk("t5_idle", busy, 0);
    // 6: sub, slt, shl literals
    push(OP_SUB, 8'h04, 8'h04, 1'b0);
    cmd_valid = 1'b0;
    wait_result();
    chk("t6_sub", res_data, 8'h00);
    chk("t6_sub_zero", res_zero, 1);
    consume();
    push(OP_SLT, 8'hFF, 8'h01, 1'b0);
    cmd_valid = 1'b0;
    wait_result();
    chk("t6_slt", res_data, 8'h01);
    consume();
    push(OP_SHL, 8'h81, 8'h01, 1'b0);
    cmd_valid = 1'b0;
    wait_result();
    chk("t6_shl", res_data, 8'h02);
    consume();
    // randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 3'($urandom_range(0, 7));
      cmd_a = 8'($urandom);
      cmd_b = 8'($urandom);
      cmd_acc = $urandom_range(0, 2) == 0;
      res_ready = $urandom_range(0, 9) < 6;
      clr_sticky = $urandom_range(0, 19) == 0;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    clr_sticky = 1'b0;
    res_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("drain_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
